// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encoding for the UART receive
// controller slice.
package uart_pkg;

    // Controller states: OFF (disabled), ARM (waiting for a quiet line), RUN
    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ARM = 2'd1,
        ST_RUN = 2'd2
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DBIT_DEF   = 8;
    localparam int IDLE_W     = $clog2(OVERSAMPLE);

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: host-side read port of the receive FIFO.
//   rd       host -> ctrl  pop request
//   r_data   ctrl -> host  FIFO head (first-word-fall-through)
//   rx_empty ctrl -> host  FIFO empty
//   rx_full  ctrl -> host  FIFO full
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF
);
    logic            rd;
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            rx_full;

    modport master (output rd, input r_data, rx_empty, rx_full);
    modport slave  (input rd, output r_data, rx_empty, rx_full);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 2^FIFO_W deep first-word-fall-through FIFO.
//   wr/w_data  write request and data (dropped when full unless popping)
//   rd         pop request (ignored when empty)
//   r_data     current head, combinational from storage
//   empty/full occupancy status
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int FIFO_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] w_data,
    input  logic            rd,
    output logic [DBIT-1:0] r_data,
    output logic            empty,
    output logic            full
);
    localparam int              DEPTH   = 1 << FIFO_W;
    localparam logic [FIFO_W:0] DEPTH_C = (FIFO_W + 1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wptr, rptr;
    logic [FIFO_W:0]   count;
    logic              do_rd, do_wr;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign r_data = mem[rptr];

    // A pop frees a slot in the same clock, so a full FIFO still accepts
    // a write when it is also being read.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= w_data;
                wptr      <= wptr + FIFO_W'(1);
            end
            if (do_rd) rptr <= rptr + FIFO_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (FIFO_W + 1)'(1);
                2'b01:   count <= count - (FIFO_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: front end for a UART receiver. Synchronizes the raw pin,
// generates the 16x oversample tick, waits for 16 consecutive idle ticks
// before letting the receiver see the line, and buffers received bytes.
//   clk/reset          clock, synchronous active-high reset
//   rx_en              enable; low forces OFF
//   dvsr               tick divisor (period dvsr+1 clocks)
//   rx_in              raw serial pin
//   rx_sync, s_tick    line and tick to the receiver
//   rx_done_tick/rx_dout  byte from the receiver
//   host               FIFO read port (rd, r_data, rx_empty, rx_full)
//   overrun/clr_err    sticky byte-lost flag and its clear
//   rx_active          high in RUN
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int DVSR_W = 11,
    parameter int FIFO_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_en,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx_in,
    output logic              rx_sync,
    output logic              s_tick,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   rx_dout,
    uart_rx_ctrl_if.slave     host,
    output logic              overrun,
    input  logic              clr_err,
    output logic              rx_active
);
    state_t            state;
    logic [DVSR_W-1:0] baud_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              sync1, sync2;
    logic              wr_req, ovf_set;

    // Two-flop synchronizer; idles high like the line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // Receiver sees a forced idle line until the link has been quiet long enough
    assign rx_sync = (state == ST_RUN) ? sync2 : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_OFF;
            baud_cnt  <= '0;
            s_tick    <= 1'b0;
            idle_cnt  <= '0;
            rx_active <= 1'b0;
        end else if (!rx_en) begin
            state     <= ST_OFF;
            baud_cnt  <= '0;
            s_tick    <= 1'b0;
            idle_cnt  <= '0;
            rx_active <= 1'b0;
        end else if (state == ST_OFF) begin
            state    <= ST_ARM;
            baud_cnt <= '0;
            s_tick   <= 1'b0;
            idle_cnt <= '0;
        end else begin
            // s_tick is registered: it is high the clock after count==dvsr
            if (baud_cnt == dvsr) begin
                baud_cnt <= '0;
                s_tick   <= 1'b1;
            end else begin
                baud_cnt <= baud_cnt + DVSR_W'(1);
                s_tick   <= 1'b0;
            end
            if (state == ST_ARM && s_tick) begin
                if (!sync2) begin
                    idle_cnt <= '0;
                end else if (idle_cnt == IDLE_W'(OVERSAMPLE - 1)) begin
                    state     <= ST_RUN;
                    rx_active <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
        end
    end

    assign wr_req  = rx_done_tick && (state == ST_RUN);
    assign ovf_set = wr_req && host.rx_full && !host.rd;

    // Set wins over clear so a coincident loss is never hidden
    always_ff @(posedge clk) begin
        if (reset)        overrun <= 1'b0;
        else if (ovf_set) overrun <= 1'b1;
        else if (clr_err) overrun <= 1'b0;
    end

    uart_rx_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_req),
        .w_data (rx_dout),
        .rd     (host.rd),
        .r_data (host.r_data),
        .empty  (host.rx_empty),
        .full   (host.rx_full)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset, rx_en, rx_in, rx_done_tick, clr_err;
    logic [10:0] dvsr;
    logic [7:0]  rx_dout;
    logic        rx_sync, s_tick, overrun, rx_active;
    int          checks = 0;
    int          errors = 0;

    uart_rx_ctrl_if #(.DBIT(8)) host();

    uart_rx_ctrl #(.DBIT(8), .DVSR_W(11), .FIFO_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .dvsr         (dvsr),
        .rx_in        (rx_in),
        .rx_sync      (rx_sync),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .host         (host.slave),
        .overrun      (overrun),
        .clr_err      (clr_err),
        .rx_active    (rx_active)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_dout = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
    endtask

    task automatic pop();
        host.rd = 1'b1;
        step();
        host.rd = 1'b0;
    endtask

    // Run until rx_active rises; returns ticks seen, spacing of ticks 2->3,
    // whether rx_sync stayed high, and whether RUN was reached in time.
    task automatic wait_run(output int nt, output int spacing, output bit sync_ok, output bit got);
        int last;
        nt = 0; spacing = 0; sync_ok = 1'b1; got = 1'b0; last = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (rx_active) begin
                got = 1'b1;
                break;
            end
            if (!rx_sync) sync_ok = 1'b0;
            if (s_tick) begin
                nt++;
                if (nt == 3) spacing = c - last;
                last = c;
            end
        end
    endtask

    initial begin
        int nt, sp;
        bit sok, got;

        reset = 1'b1; rx_en = 1'b0; rx_in = 1'b1; rx_done_tick = 1'b0;
        clr_err = 1'b0; dvsr = 11'd3; rx_dout = 8'h00; host.rd = 1'b0;
        step(); step();
        chk("rst_empty",  host.rx_empty, 1);
        chk("rst_full",   host.rx_full, 0);
        chk("rst_ovr",    overrun, 0);
        chk("rst_active", rx_active, 0);
        chk("rst_stick",  s_tick, 0);
        chk("rst_sync",   rx_sync, 1);
        chk("rst_rdata",  host.r_data, 0);

        // Quiet line: RUN on the 16th tick, one tick every 4 clocks
        reset = 1'b0; rx_en = 1'b1;
        wait_run(nt, sp, sok, got);
        chk("arm_run_reached", got, 1);
        chk("arm_ticks16",     nt, 16);
        chk("tick_spacing4",   sp, 4);
        chk("arm_sync_high",   sok, 1);

        // Disable: OFF next clock, tick stopped
        rx_en = 1'b0;
        step();
        chk("off_active", rx_active, 0);
        chk("off_stick",  s_tick, 0);

        // Line low for 5 ticks in ARM, then released: 16 high ticks to RUN
        rx_in = 1'b0;
        step(); step(); step();
        rx_en = 1'b1;
        nt = 0;
        for (int c = 0; c < 100 && nt < 5; c++) begin
            step();
            if (s_tick) nt++;
        end
        chk("low_ticks5", nt, 5);
        chk("low_not_run", rx_active, 0);
        chk("low_sync_high", rx_sync, 1);
        rx_in = 1'b1;
        wait_run(nt, sp, sok, got);
        chk("rel_run_reached", got, 1);
        chk("rel_ticks16",     nt, 16);
        chk("rel_sync_high",   sok, 1);

        // In RUN the line reaches rx_sync two clocks after rx_in
        rx_in = 1'b0;
        step();
        chk("sync_lag1", rx_sync, 1);
        step();
        chk("sync_lag2", rx_sync, 0);
        rx_in = 1'b1;
        step(); step();
        chk("sync_back", rx_sync, 1);

        // Basic queueing
        push(8'hA5);
        chk("q_nonempty", host.rx_empty, 0);
        push(8'h3C);
        chk("q_head_a5", host.r_data, 8'hA5);
        pop();
        chk("q_head_3c", host.r_data, 8'h3C);
        pop();
        chk("q_empty", host.rx_empty, 1);
        pop();
        chk("q_rd_empty_flag", host.rx_empty, 1);
        chk("q_rd_empty_data", host.r_data, 8'h00);
        push(8'h11);
        chk("q_after_empty_rd", host.r_data, 8'h11);
        pop();

        // Fill, overflow, drain (pointers wrap here)
        push(8'h01); push(8'h02); push(8'h03);
        chk("f3_not_full", host.rx_full, 0);
        push(8'h04);
        chk("f4_full", host.rx_full, 1);
        chk("f4_no_ovr", overrun, 0);
        push(8'h05);
        chk("f5_ovr", overrun, 1);
        chk("f5_full", host.rx_full, 1);
        chk("d1", host.r_data, 8'h01); pop();
        chk("d2", host.r_data, 8'h02); pop();
        chk("d3", host.r_data, 8'h03); pop();
        chk("d4", host.r_data, 8'h04); pop();
        chk("d_empty", host.rx_empty, 1);
        chk("ovr_sticky", overrun, 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // Simultaneous pop and write on full FIFO
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        host.rd = 1'b1; rx_dout = 8'h14; rx_done_tick = 1'b1;
        step();
        host.rd = 1'b0; rx_done_tick = 1'b0;
        chk("rw_no_ovr", overrun, 0);
        chk("rw_full",   host.rx_full, 1);
        chk("rw_head",   host.r_data, 8'h11);
        // clr_err coinciding with a new overrun keeps it set
        clr_err = 1'b1; rx_dout = 8'h15; rx_done_tick = 1'b1;
        step();
        clr_err = 1'b0; rx_done_tick = 1'b0;
        chk("clr_vs_set", overrun, 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_alone", overrun, 0);

        // Leaving RUN keeps the FIFO; done ticks are ignored outside RUN
        rx_en = 1'b0;
        step();
        chk("leave_active", rx_active, 0);
        chk("leave_full",   host.rx_full, 1);
        chk("leave_head",   host.r_data, 8'h11);
        push(8'h77);
        chk("off_done_no_ovr", overrun, 0);
        pop();
        push(8'h78);
        chk("off_done_no_wr", host.rx_full, 0);
        chk("off_head",       host.r_data, 8'h12);
        pop();
        chk("two_queued_head", host.r_data, 8'h13);

        // Reset in ARM with two bytes queued
        rx_en = 1'b1;
        step(); step(); step(); step(); step(); step();
        reset = 1'b1;
        step();
        chk("mid_rst_empty",  host.rx_empty, 1);
        chk("mid_rst_active", rx_active, 0);
        chk("mid_rst_stick",  s_tick, 0);
        chk("mid_rst_sync",   rx_sync, 1);
        chk("mid_rst_rdata",  host.r_data, 8'h00);

        // dvsr=0: tick every clock
        reset = 1'b0; dvsr = 11'd0;
        step(); step();
        chk("dv0_t1", s_tick, 1);
        step();
        chk("dv0_t2", s_tick, 1);
        step();
        chk("dv0_t3", s_tick, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per received byte.
REQ-002 SHALL have parameter DVSR_W, default 11: width of the baud divisor.
REQ-003 SHALL have parameter FIFO_W, default 2: log2 of receive FIFO depth (depth 4).
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_en  in  1  receive enable.
REQ-007 SHALL have port dvsr  in  DVSR_W  tick divisor; s_tick period is dvsr+1 clocks.
REQ-008 SHALL have port rx_in  in  1  raw asynchronous serial pin.
REQ-009 SHALL have port rx_sync  out  1  synchronized and gated line to the receiver.
REQ-010 SHALL have port s_tick  out  1  16x oversample tick to the receiver.
REQ-011 SHALL have port rx_done_tick  in  1  receiver byte-complete pulse.
REQ-012 SHALL have port rx_dout  in  DBIT  receiver byte, valid with rx_done_tick.
REQ-013 SHALL have port rd  in  1  pop request.
REQ-014 SHALL have port r_data  out  DBIT  FIFO head, first-word-fall-through.
REQ-015 SHALL have ports rx_empty, rx_full  out  1 each  FIFO status.
REQ-016 SHALL have port overrun  out  1  sticky byte-lost flag.
REQ-017 SHALL have port clr_err  in  1  clears overrun.
REQ-018 SHALL have port rx_active  out  1  high when state is RUN.

Function
REQ-019 Baud counter SHALL count 0..dvsr and pulse s_tick for one clock at count==dvsr, then wrap to 0; dvsr=0 gives s_tick every clock.
REQ-020 Baud counter SHALL be held at 0 with s_tick=0 while state is OFF.
REQ-021 rx_in SHALL pass through two flops (reset value 1); the synchronized line lags rx_in by 2 clocks.
REQ-022 FSM states SHALL be OFF, ARM and RUN.
REQ-023 OFF -> ARM on rx_en=1, clearing the idle counter.
REQ-024 In ARM, on each s_tick: line high increments the 4-bit idle counter, line low clears it; an s_tick with line high and idle counter==15 -> RUN.
REQ-025 rx_en=0 in any state SHALL force OFF on the next clock.
REQ-026 rx_sync SHALL equal the synchronized line in RUN and SHALL be 1 otherwise, so the receiver holds idle.
REQ-027 rx_done_tick SHALL be ignored unless state is RUN.
REQ-028 In RUN, rx_done_tick with FIFO not full SHALL write rx_dout; rx_empty deasserts the next clock.
REQ-029 rx_done_tick with FIFO full and no rd SHALL drop the byte and set overrun.
REQ-030 Simultaneous rd and rx_done_tick on a full FIFO SHALL pop and write in the same clock, with no overrun.
REQ-031 rd on an empty FIFO SHALL be ignored; r_data and pointers are unchanged.
REQ-032 rd SHALL advance the head; r_data shows the new head the next clock.
REQ-033 Pointers SHALL wrap modulo 2^FIFO_W; occupancy 0..2^FIFO_W; rx_full when occupancy==2^FIFO_W.
REQ-034 overrun SHALL stay set until clr_err; a clr_err coinciding with a new overrun SHALL leave overrun=1.
REQ-035 Leaving RUN SHALL NOT flush the FIFO or clear overrun.

Reset
REQ-036 reset SHALL have priority over all other inputs.
REQ-037 Reset SHALL give: state OFF, s_tick 0, rx_sync 1, rx_empty 1, rx_full 0, overrun 0, rx_active 0, r_data 0, pointers and counters 0, storage 0.
REQ-038 Reset mid-frame SHALL discard FIFO contents and the partial idle count.

Structure
REQ-039 Package uart_pkg SHALL hold the FSM state encoding, the OVERSAMPLE=16 constant and the DBIT default.
REQ-040 The FIFO SHALL be a sub-module, uart_rx_fifo (storage, pointers, full/empty); the FSM, baud counter and synchronizer stay in uart_rx_ctrl.

Verification
REQ-041 dvsr=3, rx_en=1, rx_in=1 -> s_tick every 4th clock; rx_active rises on the 16th s_tick after entering ARM.
REQ-042 In ARM, rx_in held 0 for 5 ticks and then 1 -> idle count restarts; RUN is reached 16 high ticks after the release; rx_sync stays 1 throughout ARM.
REQ-043 In RUN, pulse rx_done_tick with 0xA5, 0x3C -> r_data=0xA5; after rd, r_data=0x3C; after 2nd rd, rx_empty=1.
REQ-044 Five rx_done_tick pulses without rd -> rx_full=1 after the 4th, overrun=1 after the 5th, and the first four bytes are read intact.
REQ-045 Full FIFO, rd and rx_done_tick in the same clock -> overrun=0 and occupancy stays 4; clr_err coinciding with an overrun -> overrun=1.
REQ-046 reset asserted mid-ARM with 2 bytes queued -> next clock rx_empty=1, rx_active=0, s_tick=0, rx_sync=1.
